// File: rtl/slice_add_sequencer_if.sv
// Request/response bundle for slice_add_sequencer.
// The ovf signal exists only when SLICE_ADD_OVF_EN is defined.
interface slice_add_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SLICE_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/slice_add_sequencer.sv
// Serial slice adder: adds WIDTH-bit operands SLICE bits per cycle, LSB slice first.
// Optional SLICE_ADD_OVF_EN adds a registered two's-complement overflow flag (ovf).
module slice_add_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  slice_add_sequencer_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDXW-1:0]    r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_out_valid;
`ifdef SLICE_ADD_OVF_EN
  logic               r_ovf;
  logic               w_ovf;
`endif

  logic [SLICE-1:0]   w_a_slice;
  logic [SLICE-1:0]   w_b_slice;
  logic [SLICE:0]     w_slice_sum;
  logic [SLICE-1:0]   w_s;
  logic               w_c;
  logic               w_last;

  // Select the operand slices addressed by the current index
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < int'(NSLICE); i++) begin
      if (IDXW'(i) == r_idx) begin
        w_a_slice = r_a[i*SLICE +: SLICE];
        w_b_slice = r_b[i*SLICE +: SLICE];
      end
    end
  end

  assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};
  assign w_s         = w_slice_sum[SLICE-1:0];
  assign w_c         = w_slice_sum[SLICE];
  assign w_last      = (r_idx == IDXW'(NSLICE - 1));

`ifdef SLICE_ADD_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits
  assign w_ovf = w_c ^ (w_a_slice[SLICE-1] ^ w_b_slice[SLICE-1] ^ w_s[SLICE-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SLICE_ADD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NSLICE); i++) begin
            if (IDXW'(i) == r_idx) begin
              r_sum[i*SLICE +: SLICE] <= w_s;
            end
          end
          r_carry <= w_c;
          if (w_last) begin
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef SLICE_ADD_OVF_EN
            r_ovf       <= w_ovf;
`endif
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && rst_n;
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef SLICE_ADD_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Directed self-checking bench for slice_add_sequencer (WIDTH=16, SLICE=4).
module tb_slice_add_sequencer;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  slice_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  slice_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives a request and returns at the negedge after the accept edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid, sampled at negedges
  task automatic wait_result(input string name, input logic [15:0] exp_sum, input logic exp_cout);
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{16'h0006, 16'h0006, 1'b0, 16'h000C, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0E07, 16'h0209, 1'b1, 16'h1011, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors with exact latency and return-to-idle checks
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("v%0d_busy_run", i), 32'(bus.busy), 32'd1);
      repeat (NSLICE - 1) @(negedge clk);
      check($sformatf("v%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
`ifdef SLICE_ADD_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
`endif
      check($sformatf("v%0d_in_ready_done", i), 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("v%0d_in_ready_back", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
    end

    // Backpressure: result held while a new request waits
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    wait_result("bp_first", 16'h3333, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_sum%0d", k), 32'(bus.sum), 32'h3333);
      check($sformatf("bp_hold_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_taken_busy", 32'(bus.busy), 32'd1);
    wait_result("bp_second", 16'h1235, 1'b0);
    @(negedge clk);

    // Reset in the middle of an operation discards it
    send(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0001, 16'h0002, 1'b0);
    wait_result("post_rst", 16'h0003, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
